// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: decoder mem_width codes and the memory port FSM states.
package riscv_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_ctrl_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, store replication, load align/extend
// and the misalign/illegal-width check.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  width,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [3:0]  be_store;

  assign shifted = mem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be_store  = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = shifted;
    illegal   = 1'b0;
    case (width)
      MEM_B, MEM_BU: begin
        be_store  = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = width[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_H, MEM_HU: begin
        illegal   = addr_lo[0];
        be_store  = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = width[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      MEM_W: begin
        illegal = (addr_lo != 2'b00);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign be = we ? be_store : 4'b1111;

endmodule

// File: rtl/mem_port_controller.sv
// Arbitrates instruction fetch and data load/store onto one single-ported
// memory over a valid/ready handshake, with alignment, faults and timeout.
module mem_port_controller
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_fault,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [2:0]        data_width,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ready,
  output logic [31:0]       data_rdata,
  output logic              data_fault,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  mem_ctrl_state_t   state_q, state_d;
  logic              gnt_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        width_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              fault_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              any_req;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_width;
  logic              req_we;
  logic              in_idle;
  logic              timeout_hit;

  logic [1:0]        al_addr;
  logic [2:0]        al_width;
  logic              al_we;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_illegal;

  assign any_req   = data_req | fetch_req;
  assign req_addr  = data_req ? data_addr : fetch_addr;
  assign req_width = data_req ? data_width : MEM_W;
  assign req_we    = data_req & data_we;
  assign in_idle   = (state_q == IDLE);

  // One aligner serves both the grant-time legality check (live request) and
  // the access itself (latched request, constant for the whole ACCESS state).
  assign al_addr  = in_idle ? req_addr[1:0] : addr_q[1:0];
  assign al_width = in_idle ? req_width     : width_q;
  assign al_we    = in_idle ? req_we        : we_q;

  load_store_align u_align (
    .addr_lo   (al_addr),
    .width     (al_width),
    .we        (al_we),
    .wdata     (wdata_q),
    .mem_rdata (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .illegal   (al_illegal)
  );

  // Fires on the edge that would bring the wait count up to TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) &&
                       !mem_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_data_q <= 1'b0;
      addr_q     <= '0;
      width_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (any_req) begin
            gnt_data_q <= data_req;
            addr_q     <= req_addr;
            width_q    <= req_width;
            we_q       <= req_we;
            wdata_q    <= data_wdata;
            fault_q    <= al_illegal;
            rdata_q    <= '0;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            rdata_q <= we_q ? '0 : al_rdata;
            fault_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (timeout_hit) begin
              rdata_q <= '0;
              fault_q <= 1'b1;
            end
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = al_illegal ? RESP : ACCESS;
      ACCESS:  if (mem_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_valid = (state_q == ACCESS);
  assign mem_we    = mem_valid & we_q;
  assign mem_be    = mem_valid ? al_be : '0;
  assign mem_addr  = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? al_wdata : '0;

  assign fetch_ready = (state_q == RESP) & ~gnt_data_q;
  assign data_ready  = (state_q == RESP) &  gnt_data_q;
  assign fetch_rdata = fetch_ready ? rdata_q : '0;
  assign fetch_fault = fetch_ready & fault_q;
  assign data_rdata  = data_ready ? rdata_q : '0;
  assign data_fault  = data_ready & fault_q;

  assign stall = any_req & ~(fetch_ready | data_ready);

endmodule

// File: tb/tb_mem_port_controller.sv
// Directed self-checking bench for mem_port_controller with hand-computed expectations.
module tb_mem_port_controller;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] fetch_rdata;
  logic        fetch_fault;
  logic        data_req;
  logic        data_we;
  logic [2:0]  data_width;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        data_fault;
  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_controller #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_rdata (fetch_rdata),
    .fetch_fault (fetch_fault),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_width  (data_width),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_ready  (data_ready),
    .data_rdata  (data_rdata),
    .data_fault  (data_fault),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .stall       (stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single data request with mem_ready high; illegal requests skip ACCESS.
  task automatic data_xfer(input string tag, input logic we, input logic [2:0] w,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mr,
                           input logic [31:0] exp_rdata, input logic exp_fault,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    data_req = 1'b1; data_we = we; data_width = w; data_addr = a; data_wdata = wd;
    mem_rdata = mr; mem_ready = 1'b1;
    #1 check({tag, "_stall"}, stall, 1);
    tick();
    if (!exp_fault) begin
      check({tag, "_valid"}, mem_valid, 1);
      check({tag, "_be"}, mem_be, exp_be);
      check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, "_we"}, mem_we, we);
      if (we) check({tag, "_wdata"}, mem_wdata, exp_wdata);
      tick();
    end else begin
      check({tag, "_novalid"}, mem_valid, 0);
    end
    check({tag, "_ready"}, data_ready, 1);
    check({tag, "_rdata"}, data_rdata, exp_rdata);
    check({tag, "_fault"}, data_fault, exp_fault);
    tick();
    data_req = 1'b0; data_we = 1'b0;
    check({tag, "_pulse"}, data_ready, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_width = MEM_W; data_addr = '0; data_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #2;
    check("rst_valid", mem_valid, 0);
    check("rst_be", mem_be, 0);
    check("rst_fready", fetch_ready, 0);
    check("rst_dready", data_ready, 0);
    check("rst_stall", stall, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Fetch, ready tied high.
    fetch_req = 1'b1; fetch_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h00500093;
    tick();
    check("f_valid", mem_valid, 1);
    check("f_be", mem_be, 4'b1111);
    check("f_addr", mem_addr, 32'h100);
    check("f_early", fetch_ready, 0);
    tick();
    check("f_ready", fetch_ready, 1);
    check("f_rdata", fetch_rdata, 32'h00500093);
    check("f_fault", fetch_fault, 0);
    check("f_valid_off", mem_valid, 0);
    tick();
    fetch_req = 1'b0;
    check("f_pulse", fetch_ready, 0);

    // Simultaneous store byte and fetch: data first.
    data_req = 1'b1; data_we = 1'b1; data_width = MEM_B; data_addr = 32'h203;
    data_wdata = 32'h000000AB; fetch_req = 1'b1; fetch_addr = 32'h104; mem_rdata = 32'h12345678;
    tick();
    check("sb_we", mem_we, 1);
    check("sb_be", mem_be, 4'b1000);
    check("sb_wdata", mem_wdata, 32'hABABABAB);
    check("sb_addr", mem_addr, 32'h200);
    tick();
    check("sb_dready", data_ready, 1);
    check("sb_fready", fetch_ready, 0);
    check("sb_rdata", data_rdata, 0);
    tick();
    data_req = 1'b0; data_we = 1'b0;
    tick();
    check("sbf_addr", mem_addr, 32'h104);
    check("sbf_we", mem_we, 0);
    tick();
    check("sbf_ready", fetch_ready, 1);
    check("sbf_rdata", fetch_rdata, 32'h12345678);
    tick();
    fetch_req = 1'b0;

    data_xfer("sh", 1'b1, MEM_H, 32'h202, 32'h00001234, 32'h0, 32'h0, 1'b0, 4'b1100, 32'h12341234);
    data_xfer("sw", 1'b1, MEM_W, 32'h204, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
    data_xfer("lb", 1'b0, MEM_B, 32'h403, 32'h0, 32'h80F07F01, 32'hFFFFFF80, 1'b0, 4'b1111, 32'h0);
    data_xfer("lbu", 1'b0, MEM_BU, 32'h403, 32'h0, 32'h80F07F01, 32'h00000080, 1'b0, 4'b1111, 32'h0);
    data_xfer("lh", 1'b0, MEM_H, 32'h402, 32'h0, 32'h80F07F01, 32'hFFFF80F0, 1'b0, 4'b1111, 32'h0);
    data_xfer("lhu", 1'b0, MEM_HU, 32'h400, 32'h0, 32'h80F07F01, 32'h00007F01, 1'b0, 4'b1111, 32'h0);
    data_xfer("lw_mis", 1'b0, MEM_W, 32'h102, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    data_xfer("w011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    data_xfer("lh_mis", 1'b0, MEM_H, 32'h101, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);

    // Misaligned fetch.
    fetch_req = 1'b1; fetch_addr = 32'h102;
    tick();
    check("fm_novalid", mem_valid, 0);
    check("fm_ready", fetch_ready, 1);
    check("fm_fault", fetch_fault, 1);
    tick();
    fetch_req = 1'b0;

    // Timeout: mem_ready held low.
    data_req = 1'b1; data_width = MEM_W; data_addr = 32'h300; mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
    tick();
    n = 0;
    while (mem_valid && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_ready", data_ready, 1);
    check("to_fault", data_fault, 1);
    check("to_rdata", data_rdata, 0);
    tick();
    data_req = 1'b0;

    // Ready after 5 wait cycles.
    data_req = 1'b1; data_addr = 32'h304; mem_rdata = 32'hCAFEF00D;
    tick();
    repeat (5) tick();
    check("w5_valid", mem_valid, 1);
    check("w5_hold_addr", mem_addr, 32'h304);
    mem_ready = 1'b1;
    tick();
    check("w5_ready", data_ready, 1);
    check("w5_fault", data_fault, 0);
    check("w5_rdata", data_rdata, 32'hCAFEF00D);
    tick();
    data_req = 1'b0;

    // Reset during ACCESS.
    fetch_req = 1'b1; fetch_addr = 32'h108; mem_ready = 1'b0;
    tick();
    check("ra_valid", mem_valid, 1);
    #2 reset = 1'b1; fetch_req = 1'b0;
    #1;
    check("ra_valid_off", mem_valid, 0);
    check("ra_be", mem_be, 0);
    check("ra_addr", mem_addr, 0);
    check("ra_stall", stall, 0);
    n = 0;
    repeat (3) begin
      tick();
      if (fetch_ready || data_ready) n++;
    end
    check("ra_no_pulse", 32'(n), 0);
    reset = 1'b0;
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h10C; mem_ready = 1'b1; mem_rdata = 32'h00A00113;
    tick();
    check("ra2_valid", mem_valid, 1);
    tick();
    check("ra2_ready", fetch_ready, 1);
    check("ra2_rdata", fetch_rdata, 32'h00A00113);
    check("ra2_fault", fetch_fault, 0);
    tick();
    fetch_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
